// File: rtl/branch_feed_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_feed_queue: resolved-branch FIFO feeding the predictor, re-aligning |
// | its registered miss flag and keeping branch/miss statistics. Rev 1.0       |
// +----------------------------------------------------------------------------+
module branch_feed_queue #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_W-1:0]          in_id,
  input  logic                     in_outcome,
  output logic                     bp_issue,
  output logic [ID_W-1:0]          bp_branchID,
  output logic                     bp_outcome,
  input  logic                     bp_miss,
  input  logic                     stats_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     miss_pulse,
  output logic [ID_W-1:0]          miss_id
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};

  logic [ID_W-1:0]    r_mem_id  [DEPTH];
  logic               r_mem_out [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_issue;
  logic [ID_W-1:0]    r_bid;
  logic               r_bout;
  logic               r_pend_v;
  logic [ID_W-1:0]    r_pend_id;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_miss;
  logic               r_pulse;
  logic [ID_W-1:0]    r_miss_id;

  logic w_push;
  logic w_pop;
  logic w_retire;

  assign in_ready = (r_count < c_depth);
  assign w_push   = in_valid && in_ready;
  // Pop decision uses pre-edge occupancy, so a fresh entry is never issued the cycle it lands.
  assign w_pop    = (r_count != '0);
  assign w_retire = r_pend_v;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]  <= in_id;
      r_mem_out[r_wr_ptr] <= in_outcome;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_issue   <= 1'b0;
      r_bid     <= '0;
      r_bout    <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_id <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_bid    <= r_mem_id[r_rd_ptr];
        r_bout   <= r_mem_out[r_rd_ptr];
      end
      r_issue   <= w_pop;
      r_pend_v  <= r_issue;
      r_pend_id <= r_bid;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The pend stage lines up the predictor's registered miss with the branch it judged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_total   <= '0;
      r_miss    <= '0;
      r_pulse   <= 1'b0;
      r_miss_id <= '0;
    end else if (stats_clr) begin
      r_total   <= '0;
      r_miss    <= '0;
      r_pulse   <= 1'b0;
      r_miss_id <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_retire) begin
        if (r_total != c_cnt_max) begin
          r_total <= r_total + 1'b1;
        end
        if (bp_miss) begin
          if (r_miss != c_cnt_max) begin
            r_miss <= r_miss + 1'b1;
          end
          r_pulse   <= 1'b1;
          r_miss_id <= r_pend_id;
        end
      end
    end
  end

  assign bp_issue    = r_issue;
  assign bp_branchID = r_bid;
  assign bp_outcome  = r_bout;
  assign count       = r_count;
  assign total_cnt   = r_total;
  assign miss_cnt    = r_miss;
  assign miss_pulse  = r_pulse;
  assign miss_id     = r_miss_id;

endmodule
`default_nettype wire

// File: tb/tb_branch_feed_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_feed_queue: directed + random stimulus against a queue model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_branch_feed_queue;

  localparam int DEPTH = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [ID_W-1:0]  in_id;
  logic             in_outcome;
  logic             bp_issue;
  logic [ID_W-1:0]  bp_branchID;
  logic             bp_outcome;
  logic             bp_miss;
  logic             stats_clr;
  logic [3:0]       count;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             miss_pulse;
  logic [ID_W-1:0]  miss_id;

  branch_feed_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_outcome(in_outcome), .bp_issue(bp_issue),
    .bp_branchID(bp_branchID), .bp_outcome(bp_outcome), .bp_miss(bp_miss),
    .stats_clr(stats_clr), .count(count), .total_cnt(total_cnt),
    .miss_cnt(miss_cnt), .miss_pulse(miss_pulse), .miss_id(miss_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [ID_W-1:0] id; logic o; } ent_t;
  typedef struct { bit v; logic [ID_W-1:0] id; } fl_t;

  // Reference: queued branches, and issue history (retire judges the one issued two edges earlier).
  ent_t            mq[$];
  fl_t             fl[$];
  logic [ID_W-1:0] m_bid;
  logic            m_bout;
  int              m_total, m_miss;
  bit              m_pulse;
  logic [ID_W-1:0] m_mid;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fl.delete();
    m_bid = '0; m_bout = 1'b0;
    m_total = 0; m_miss = 0; m_pulse = 0; m_mid = '0;
  endtask

  task automatic model_edge();
    fl_t  r;
    ent_t e;
    bit   acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = in_valid && (mq.size() < DEPTH);
    m_pulse = 0;
    if (fl.size() == 2) begin
      r = fl.pop_front();
      if (r.v && !stats_clr) begin
        if (m_total < MAXC) m_total++;
        if (bp_miss) begin
          if (m_miss < MAXC) m_miss++;
          m_mid   = r.id;
          m_pulse = 1;
        end
      end
    end
    if (stats_clr) begin
      m_total = 0; m_miss = 0; m_mid = '0; m_pulse = 0;
    end
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_bid = e.id; m_bout = e.o;
      fl.push_back('{v: 1'b1, id: e.id});
    end else begin
      fl.push_back('{v: 1'b0, id: m_bid});
    end
    if (acc) mq.push_back('{id: in_id, o: in_outcome});
  endtask

  task automatic check_all();
    chk("in_ready",    in_ready, (mq.size() < DEPTH));
    chk("count",       count, mq.size());
    chk("bp_issue",    bp_issue, (fl.size() > 0) ? fl[fl.size()-1].v : 1'b0);
    chk("bp_branchID", bp_branchID, m_bid);
    chk("bp_outcome",  bp_outcome, m_bout);
    chk("total_cnt",   total_cnt, m_total);
    chk("miss_cnt",    miss_cnt, m_miss);
    chk("miss_pulse",  miss_pulse, m_pulse);
    chk("miss_id",     miss_id, m_mid);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [ID_W-1:0] exp_order[$];
    logic [ID_W-1:0] mids[$];
    int              pat[8];
    logic [ID_W-1:0] eid;

    rst_n = 1'b0; in_valid = 1'b0; in_id = '0; in_outcome = 1'b0;
    bp_miss = 1'b0; stats_clr = 1'b0;
    model_reset();
    #2;
    check_all();
    rst_n = 1'b1;

    // Single-branch latency: accept at edge 1, issue after edge 2, retire at edge 4.
    in_valid = 1'b1; in_id = 3'd5; in_outcome = 1'b1;
    step();
    chk("lat_no_issue_e1", bp_issue, 1'b0);
    in_valid = 1'b0;
    step();
    chk("lat_issue_e2", bp_issue, 1'b1);
    chk("lat_id_e2", bp_branchID, 3'd5);
    step();
    bp_miss = 1'b1;
    step();
    chk("lat_total", total_cnt, 1);
    chk("lat_miss", miss_cnt, 1);
    chk("lat_pulse", miss_pulse, 1'b1);
    chk("lat_mid", miss_id, 3'd5);
    bp_miss = 1'b0;
    step();
    chk("lat_pulse_drop", miss_pulse, 1'b0);

    // Bursts of pushes across the pointer wrap; issued IDs must follow push order.
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 != 2) && (i < 16);
      in_id = ID_W'(i); in_outcome = $urandom_range(0, 1);
      if (in_valid) exp_order.push_back(in_id);
      step();
      if (bp_issue) begin
        eid = (exp_order.size() > 0) ? exp_order.pop_front() : '1;
        chk("fifo_order", bp_branchID, eid);
      end
    end
    in_valid = 1'b0;
    chk("fifo_all_issued", exp_order.size(), 0);

    // Miss alignment: IDs 0..7 back to back, miss pattern 1,0,0,1,0,0,0,1.
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    pat = '{1, 0, 0, 1, 0, 0, 0, 1};
    for (int j = 0; j < 12; j++) begin
      in_valid = (j < 8);
      in_id = ID_W'(j); in_outcome = j[0];
      bp_miss = (j >= 3 && j < 11) ? pat[j-3][0] : 1'b0;
      step();
      if (miss_pulse) mids.push_back(miss_id);
    end
    in_valid = 1'b0; bp_miss = 1'b0;
    chk("align_total", total_cnt, 8);
    chk("align_miss", miss_cnt, 3);
    chk("align_nmid", mids.size(), 3);
    if (mids.size() == 3) begin
      chk("align_mid0", mids[0], 3'd0);
      chk("align_mid1", mids[1], 3'd3);
      chk("align_mid2", mids[2], 3'd7);
    end

    // stats_clr on the same edge as a missed retire: clear wins, next retire counts.
    in_valid = 1'b1; in_id = 3'd2; step();
    in_id = 3'd6; step();
    in_valid = 1'b0; step();
    stats_clr = 1'b1; bp_miss = 1'b1; step();
    chk("clr_total", total_cnt, 0);
    chk("clr_miss", miss_cnt, 0);
    chk("clr_pulse", miss_pulse, 1'b0);
    stats_clr = 1'b0; step();
    chk("clr_next_total", total_cnt, 1);
    chk("clr_next_miss", miss_cnt, 1);
    chk("clr_next_mid", miss_id, 3'd6);
    bp_miss = 1'b0; step();

    // Random traffic; late phase has no clears and heavy misses to reach saturation.
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_id      = ID_W'($urandom);
      in_outcome = $urandom_range(0, 1);
      bp_miss    = (k < 200) ? $urandom_range(0, 1) : ($urandom_range(0, 9) < 8);
      stats_clr  = (k < 200) && ($urandom_range(0, 31) == 0);
      step();
    end
    stats_clr = 1'b0;
    chk("sat_total", total_cnt, MAXC);
    chk("sat_miss", miss_cnt, MAXC);

    // Asynchronous reset between edges with branches in flight.
    in_valid = 1'b1; bp_miss = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_id = ID_W'(k + 1);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_issue", bp_issue, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    step();
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rst_no_retire", total_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
